// File: rtl/svm_slice_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : svm_slice_ctrl
// Brief    : Pixel-stream sequencer and drain controller for one row of SVM
//            slice accumulators (dvi/newblock/download, coef address, results).
// Revision : 1.0
// ============================================================================
module svm_slice_ctrl #(
    parameter int DWIDTH    = 8,
    parameter int BLOCKSIZE = 32,
    parameter int WINCOLS   = 8,
    parameter int WPI       = 40,
    parameter int CAW       = $clog2(WINCOLS * BLOCKSIZE)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              fv_in,
    input  logic              dv_in,
    input  logic [DWIDTH-1:0] data_in,
    output logic [CAW-1:0]    coef_addr,
    output logic [DWIDTH-1:0] data_out,
    output logic              dvi,
    output logic              newblock,
    output logic              download,
    input  logic [31:0]       regin,
    output logic              res_dv,
    output logic [15:0]       res_idx,
    output logic [31:0]       res_data,
    output logic              busy,
    output logic              frame_drop
);

    localparam int c_pxw = (BLOCKSIZE > 1) ? $clog2(BLOCKSIZE) : 1;
    localparam int c_bkw = (WINCOLS > 1) ? $clog2(WINCOLS) : 1;
    localparam int c_dcw = (WPI > 1) ? $clog2(WPI) : 1;
    localparam logic [c_pxw-1:0] c_px_last = c_pxw'(BLOCKSIZE - 1);
    localparam logic [c_bkw-1:0] c_bk_last = c_bkw'(WINCOLS - 1);
    localparam logic [c_dcw-1:0] c_dc_last = c_dcw'(WPI - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_fv_d;
    logic [c_pxw-1:0]   r_px;
    logic [c_bkw-1:0]   r_blk;
    logic [c_dcw-1:0]   r_dcnt;
    logic               w_rise;
    logic               w_start;
    logic               w_pix;
    logic               w_drop;
    logic               w_px_last;
    logic               w_bk_last;
    logic               w_dc_last;

    // A pixel arriving on the very cycle the frame is accepted is counted.
    assign w_rise    = fv_in && !r_fv_d;
    assign w_start   = (r_state == S_IDLE) && w_rise && enable;
    assign w_pix     = fv_in && dv_in && ((r_state == S_RUN) || w_start);
    assign w_drop    = (r_state == S_DRAIN) && w_rise;
    assign w_px_last = (r_px == c_px_last);
    assign w_bk_last = (r_blk == c_bk_last);
    assign w_dc_last = (r_dcnt == c_dc_last);

    always_comb begin
        w_state_nxt = r_state;
        download    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (!fv_in) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy     = 1'b1;
                download = 1'b1;
                if (w_dc_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_fv_d     <= 1'b0;
            r_px       <= '0;
            r_blk      <= '0;
            r_dcnt     <= '0;
            coef_addr  <= '0;
            data_out   <= '0;
            dvi        <= 1'b0;
            newblock   <= 1'b0;
            res_dv     <= 1'b0;
            res_idx    <= '0;
            res_data   <= '0;
            frame_drop <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fv_d     <= fv_in;
            dvi        <= w_pix;
            newblock   <= w_pix && w_px_last;
            frame_drop <= w_drop;
            res_dv     <= download;

            if (dv_in) data_out <= data_in;

            if (download) begin
                res_idx  <= 16'(r_dcnt);
                res_data <= regin;
                r_dcnt   <= w_dc_last ? '0 : r_dcnt + 1'b1;
            end

            // Counters are parked at zero during the drain so the next frame starts at address 0.
            if (w_pix) begin
                coef_addr <= CAW'(r_blk) * CAW'(BLOCKSIZE) + CAW'(r_px);
                r_px      <= w_px_last ? '0 : r_px + 1'b1;
                if (w_px_last) r_blk <= w_bk_last ? '0 : r_blk + 1'b1;
            end else if (r_state == S_DRAIN) begin
                r_px  <= '0;
                r_blk <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/svm_slice_ctrl.md
Name: svm_slice_ctrl

Overview:
Sequencer for one row of SVM slice accumulators in the slidevm process.
- Turns the incoming pixel stream (frame valid + data valid) into the per-slice control pulses: dvi, newblock, download.
- Generates the coefficient-memory read address and keeps pixel data aligned with the coefficient.
- At end of frame, runs a drain (download) phase that empties the slice shift register and presents its WPI partial sums as a result stream.

Parameters:
DWIDTH, 8, pixel data width
BLOCKSIZE, 32, pixels per block; power of 2
WINCOLS, 8, blocks per window; power of 2
WPI, 40, window sums held in a slice shift register; equals drain length
CAW, $clog2(WINCOLS*BLOCKSIZE), coefficient address width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  sampled only at fv_in rising edge; 0 = frame ignored
fv_in  in  1  frame valid
dv_in  in  1  pixel valid, qualified by fv_in
data_in  in  DWIDTH  pixel
coef_addr  out  CAW  coefficient ROM address (ROM has 1-cycle read latency)
data_out  out  DWIDTH  pixel delayed 1 cycle, aligned with ROM output
dvi  out  1  slice data valid, aligned with data_out
newblock  out  1  last pixel of a block, aligned with dvi
download  out  1  slice drain/clear strobe
regin  in  32  slice regout (shift register output)
res_dv  out  1  result valid
res_idx  out  16  window index of result, 0..WPI-1
res_data  out  32  signed window partial sum
busy  out  1  high in RUN or DRAIN
frame_drop  out  1  1-cycle pulse: frame start rejected

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- States: IDLE, RUN, DRAIN.
  - IDLE: fv_in rising and enable=1 -> RUN; px and blk counters cleared.
  - RUN: each cycle with fv_in & dv_in:
    - coef_addr <= blk*BLOCKSIZE + px;
    - px increments, wrapping at BLOCKSIZE-1;
    - blk increments when px wraps, wrapping at WINCOLS-1.
  - RUN -> DRAIN on fv_in falling edge.
  - DRAIN: download=1 for exactly WPI consecutive cycles, then -> IDLE.
- Pixel pipeline:
  - dvi = fv_in&dv_in registered 1 cycle; data_out = data_in registered on every dv_in.
  - newblock registered alongside dvi; high for the pixel where px==BLOCKSIZE-1.
  - dvi and newblock are never high while download=1.
- Drain:
  - On every download cycle k (0..WPI-1), regin is captured.
  - Next cycle: res_dv=1, res_idx=k, res_data=regin.
  - Output is exactly WPI results, contiguous; no backpressure.
- busy = state != IDLE.
- Boundaries:
  - dv_in outside fv_in is ignored.
  - fv_in rising while in DRAIN: the drain completes, frame_drop pulses, and that frame is ignored; control waits for the next rising edge in IDLE.
  - enable=0 at frame start: stay IDLE, no frame_drop.
  - fv_in falling in the same cycle as a final dv_in: that pixel is still issued; download starts the cycle after its dvi.
  - A frame with zero pixels still drains WPI results.
  - Counter wrap (blk==WINCOLS-1, px==BLOCKSIZE-1) returns both to 0 on the next pixel; coef_addr wraps to 0.
- Reset mid-operation: asynchronous return to IDLE, outputs 0, counters cleared, no partial result stream.
- enable changing mid-frame has no effect until the next frame start.

Test Plan:
Use BLOCKSIZE=4, WINCOLS=2, WPI=3 for all scenarios.
1. Frame of 10 contiguous pixels -> coef_addr sequence 0,1,2,3,4,5,6,7,0,1; newblock on the dvi of pixels 3 and 7; data_out equals data_in delayed 1.
2. fv_in falls after scenario 1 with regin driven 100,-5,7 during download -> download high exactly 3 cycles; res_dv 3 cycles with idx 0,1,2 and data 100,-5,7; busy low afterwards.
3. Gappy dv_in (1,0,0,1,1,0,1) -> addresses 0,1,2,3 issued only on valid cycles; dvi never coincides with download.
4. New fv_in rising in the second DRAIN cycle -> drain still 3 cycles, frame_drop one pulse, no dvi for that frame.
5. reset_n low in the 6th RUN pixel -> all outputs 0 immediately; the next frame restarts at coef_addr 0.
6. enable=0 at frame start -> no dvi, no download, busy 0, frame_drop 0.
